// File: rtl/mipi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_tx_pkg
// Description : Shared definitions for the MIPI-style HS transmit path.
//               Holds the serializer state encodings and the default burst
//               framing constants. The RX sync detector uses the same
//               SYNC word.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_tx_pkg;

    // Serializer state register type and encodings
    typedef logic [2:0] txState_t;

    localparam txState_t c_ST_IDLE  = 3'd0;
    localparam txState_t c_ST_SYNC  = 3'd1;
    localparam txState_t c_ST_DATA  = 3'd2;
    localparam txState_t c_ST_TRAIL = 3'd3;
    localparam txState_t c_ST_EXIT  = 3'd4;

    // Default burst framing
    localparam logic [7:0] c_SYNC_WORD   = 8'hB8;
    localparam int         c_TRAIL_BITS  = 8;
    localparam int         c_EXIT_CYCLES = 4;

endpackage : mipi_tx_pkg
`default_nettype wire

// File: rtl/tx_shift8.sv
`default_nettype none
// ============================================================================
// Module      : tx_shift8
// Description : 8-bit load register with a 3-bit bit counter and a
//               bit-select output. Bits are presented LSB-first by walking
//               the counter rather than physically shifting the data.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               i_load     - load i_loadData and restart the counter at 0
//               i_loadData - byte to load
//               i_advance  - increment the bit counter (ignored on load)
//               o_bitCnt   - current bit index
//               o_bitSel   - register bit selected by o_bitCnt
//               o_msb      - register bit 7
// Revision    : 1.0 - initial release
// ============================================================================
module tx_shift8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_loadData,
    input  logic       i_advance,
    output logic [2:0] o_bitCnt,
    output logic       o_bitSel,
    output logic       o_msb
);

    logic [7:0] r_shift;
    logic [2:0] r_bitCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= 8'h00;
            r_bitCnt <= 3'd0;
        end else if (i_load) begin
            r_shift  <= i_loadData;
            r_bitCnt <= 3'd0;
        end else if (i_advance) begin
            r_bitCnt <= r_bitCnt + 3'd1;
        end
    end

    assign o_bitCnt = r_bitCnt;
    assign o_bitSel = r_shift[r_bitCnt];
    assign o_msb    = r_shift[7];

endmodule : tx_shift8
`default_nettype wire

// File: rtl/tx_hs_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tx_hs_serializer
// Description : HS lane serializer. Frames the upstream byte stream as a
//               burst: SYNC word (LSB-first), payload bytes (LSB-first),
//               trail bits (inverse of the last bit sent), then an idle
//               exit gap. One lane bit per TxDDRClk cycle.
// Ports       : TxDDRClk    - bit clock, rising edge
//               TxRst       - asynchronous active-high reset
//               TxValid     - upstream byte valid (level, whole packet)
//               TxDataIn    - upstream byte, taken at the end of a
//                             TxByteReady cycle when TxValid=1
//               TxByteReady - byte slot (state/counter decode only)
//               TxSerialOut - serial lane bit
//               TxHsActive  - high from first SYNC bit to last trail bit
//               TxPktDone   - one-cycle pulse with the last trail bit
// Revision    : 1.0 - initial release
// ============================================================================
module tx_hs_serializer
    import mipi_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD   = c_SYNC_WORD,
    parameter int          TRAIL_BITS  = c_TRAIL_BITS,
    parameter int          EXIT_CYCLES = c_EXIT_CYCLES
) (
    input  logic       TxDDRClk,
    input  logic       TxRst,
    input  logic       TxValid,
    input  logic [7:0] TxDataIn,
    output logic       TxByteReady,
    output logic       TxSerialOut,
    output logic       TxHsActive,
    output logic       TxPktDone
);

    localparam logic [7:0] c_TRAIL_LAST = 8'(TRAIL_BITS - 1);
    localparam logic [7:0] c_EXIT_LAST  = 8'(EXIT_CYCLES - 1);

    txState_t   r_state;
    logic [7:0] r_trailCnt;
    logic [7:0] r_exitCnt;
    logic       r_trailBit;
    logic       r_serial;
    logic       r_active;
    logic       r_pktDone;

    logic       w_load;
    logic [7:0] w_loadData;
    logic       w_advance;
    logic [2:0] w_bitCnt;
    logic       w_bitSel;
    logic       w_msb;
    logic       w_byteSlot;

    // The SYNC word is loaded into the same register as payload bytes, so
    // SYNC and DATA share one bit-select path and one trail-bit source.
    tx_shift8 u_shift (
        .clk        (TxDDRClk),
        .rst        (TxRst),
        .i_load     (w_load),
        .i_loadData (w_loadData),
        .i_advance  (w_advance),
        .o_bitCnt   (w_bitCnt),
        .o_bitSel   (w_bitSel),
        .o_msb      (w_msb)
    );

    // Last bit of the current byte: decision point for the next byte
    assign w_byteSlot = ((r_state == c_ST_SYNC) || (r_state == c_ST_DATA))
                        && (w_bitCnt == 3'd7);

    always_comb begin
        w_load     = 1'b0;
        w_loadData = TxDataIn;
        w_advance  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_load     = TxValid;
                w_loadData = SYNC_WORD;
            end
            c_ST_SYNC, c_ST_DATA: begin
                w_load    = w_byteSlot & TxValid;
                w_advance = ~w_byteSlot;
            end
            default: begin
                w_load    = 1'b0;
            end
        endcase
    end

    // Lane outputs are registered one cycle behind the state that produces
    // them, giving the pad stage glitch-free levels.
    always_ff @(posedge TxDDRClk or posedge TxRst) begin
        if (TxRst) begin
            r_state    <= c_ST_IDLE;
            r_trailCnt <= 8'd0;
            r_exitCnt  <= 8'd0;
            r_trailBit <= 1'b0;
            r_serial   <= 1'b0;
            r_active   <= 1'b0;
            r_pktDone  <= 1'b0;
        end else begin
            r_serial  <= 1'b0;
            r_active  <= 1'b0;
            r_pktDone <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (TxValid) begin
                        r_state <= c_ST_SYNC;
                    end
                end
                c_ST_SYNC, c_ST_DATA: begin
                    r_serial <= w_bitSel;
                    r_active <= 1'b1;
                    if (w_byteSlot) begin
                        if (TxValid) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            // Trail opposes the final bit so the last
                            // transition is always visible to the receiver.
                            r_state    <= c_ST_TRAIL;
                            r_trailBit <= ~w_msb;
                            r_trailCnt <= 8'd0;
                        end
                    end
                end
                c_ST_TRAIL: begin
                    r_serial <= r_trailBit;
                    r_active <= 1'b1;
                    if (r_trailCnt == c_TRAIL_LAST) begin
                        r_pktDone <= 1'b1;
                        r_state   <= c_ST_EXIT;
                        r_exitCnt <= 8'd0;
                    end else begin
                        r_trailCnt <= r_trailCnt + 8'd1;
                    end
                end
                c_ST_EXIT: begin
                    if (r_exitCnt == c_EXIT_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_exitCnt <= r_exitCnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign TxByteReady = w_byteSlot;
    assign TxSerialOut = r_serial;
    assign TxHsActive  = r_active;
    assign TxPktDone   = r_pktDone;

endmodule : tx_hs_serializer
`default_nettype wire

// File: tb/tb_tx_hs_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_hs_serializer
// Description : Directed self-checking bench for tx_hs_serializer.
//               Cycle index k counts post-edge samples, k=0 being the edge
//               that first sees TxValid=1 in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_hs_serializer;

    logic       TxDDRClk = 1'b0;
    logic       TxRst;
    logic       TxValid;
    logic [7:0] TxDataIn;
    logic       TxByteReady;
    logic       TxSerialOut;
    logic       TxHsActive;
    logic       TxPktDone;

    int checks = 0;
    int errors = 0;

    tx_hs_serializer dut (
        .TxDDRClk    (TxDDRClk),
        .TxRst       (TxRst),
        .TxValid     (TxValid),
        .TxDataIn    (TxDataIn),
        .TxByteReady (TxByteReady),
        .TxSerialOut (TxSerialOut),
        .TxHsActive  (TxHsActive),
        .TxPktDone   (TxPktDone)
    );

    always #5 TxDDRClk = ~TxDDRClk;

    task automatic tick();
        @(posedge TxDDRClk);
        #1;
    endtask

    task automatic drain(input int n);
        TxValid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        TxRst    = 1'b1;
        TxValid  = 1'b0;
        TxDataIn = 8'h00;
        tick();
        tick();
        checks++;
        if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: outputs ser/act/rdy/done=%b%b%b%b expected 0000",
                     TxSerialOut, TxHsActive, TxByteReady, TxPktDone);
        end
        TxRst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d: ser/act/rdy/done=%b%b%b%b expected 0000",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone);
            end
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] sw = 8'hB8;
        logic [7:0] pd = 8'hA5;
        logic eS, eA, eR, eD;
        TxDataIn = pd;
        TxValid  = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            tick();
            eS = 1'b0;
            if (k >= 1 && k <= 8)       eS = sw[k-1];
            else if (k >= 9 && k <= 16) eS = pd[k-9];
            eA = (k >= 1 && k <= 24);
            eR = (k == 7 || k == 15);
            eD = (k == 24);
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== {eS, eA, eR, eD}) begin
                errors++;
                $display("FAIL single_byte k=%0d: ser/act/rdy/done=%b%b%b%b expected %b%b%b%b",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone, eS, eA, eR, eD);
            end
            if (k == 8) begin
                TxValid  = 1'b0;
                TxDataIn = 8'h00;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sw = 8'hB8;
        logic [7:0] by [3] = '{8'h01, 8'hFF, 8'h80};
        logic [7:0] cur;
        logic eS, eA, eR, eD;
        int actCnt = 0;
        TxDataIn = by[0];
        TxValid  = 1'b1;
        for (int k = 0; k <= 46; k++) begin
            tick();
            eS = 1'b0;
            if (k >= 1 && k <= 8) begin
                eS = sw[k-1];
            end else if (k >= 9 && k <= 32) begin
                cur = by[(k-9)/8];
                eS  = cur[(k-9)%8];
            end
            eA = (k >= 1 && k <= 40);
            eR = (k == 7 || k == 15 || k == 23 || k == 31);
            eD = (k == 40);
            if (TxHsActive === 1'b1) actCnt++;
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== {eS, eA, eR, eD}) begin
                errors++;
                $display("FAIL back_to_back k=%0d: ser/act/rdy/done=%b%b%b%b expected %b%b%b%b",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone, eS, eA, eR, eD);
            end
            if (k == 8)  TxDataIn = by[1];
            if (k == 16) TxDataIn = by[2];
            if (k == 24) begin
                TxValid  = 1'b0;
                TxDataIn = 8'h00;
            end
        end
        checks++;
        if (actCnt != 40) begin
            errors++;
            $display("FAIL back_to_back_active_len: got %0d cycles expected 40", actCnt);
        end
    endtask

    task automatic test_empty_packet();
        logic [7:0] sw = 8'hB8;
        logic eS, eA, eR, eD;
        int doneCnt = 0;
        TxDataIn = 8'hFF;
        TxValid  = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            tick();
            eS = (k >= 1 && k <= 8) ? sw[k-1] : 1'b0;
            eA = (k >= 1 && k <= 16);
            eR = (k == 7);
            eD = (k == 16);
            if (TxPktDone === 1'b1) doneCnt++;
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== {eS, eA, eR, eD}) begin
                errors++;
                $display("FAIL empty_packet k=%0d: ser/act/rdy/done=%b%b%b%b expected %b%b%b%b",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone, eS, eA, eR, eD);
            end
            if (k == 3) TxValid = 1'b0;
        end
        checks++;
        if (doneCnt != 1) begin
            errors++;
            $display("FAIL empty_packet_done_count: got %0d pulses expected 1", doneCnt);
        end
    endtask

    task automatic test_data_hold();
        logic [7:0] sw = 8'hB8;
        logic [7:0] b0 = 8'h3C;
        logic [7:0] b1 = 8'h4B;
        logic eS, eA, eR, eD;
        TxDataIn = 8'($urandom);
        TxValid  = 1'b1;
        for (int k = 0; k <= 38; k++) begin
            tick();
            eS = 1'b0;
            if (k >= 1 && k <= 8)        eS = sw[k-1];
            else if (k >= 9 && k <= 16)  eS = b0[k-9];
            else if (k >= 17 && k <= 24) eS = b1[k-17];
            else if (k >= 25 && k <= 32) eS = 1'b1;
            eA = (k >= 1 && k <= 32);
            eR = (k == 7 || k == 15 || k == 23);
            eD = (k == 32);
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== {eS, eA, eR, eD}) begin
                errors++;
                $display("FAIL data_hold k=%0d: ser/act/rdy/done=%b%b%b%b expected %b%b%b%b",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone, eS, eA, eR, eD);
            end
            if (k == 7)       TxDataIn = b0;
            else if (k == 15) TxDataIn = b1;
            else              TxDataIn = 8'($urandom);
            if (k == 16) TxValid = 1'b0;
        end
    endtask

    task automatic test_rearm();
        logic [7:0] sw = 8'hB8;
        logic [7:0] pd = 8'hC3;
        logic eS, eA, eR, eD;
        TxDataIn = pd;
        TxValid  = 1'b1;
        for (int k = 0; k <= 38; k++) begin
            tick();
            eS = 1'b0;
            if (k >= 1 && k <= 8)        eS = sw[k-1];
            else if (k >= 9 && k <= 16)  eS = pd[k-9];
            else if (k >= 30 && k <= 37) eS = sw[k-30];
            eA = (k >= 1 && k <= 24) || (k >= 30);
            eR = (k == 7 || k == 15 || k == 36);
            eD = (k == 24);
            checks++;
            if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== {eS, eA, eR, eD}) begin
                errors++;
                $display("FAIL rearm k=%0d: ser/act/rdy/done=%b%b%b%b expected %b%b%b%b",
                         k, TxSerialOut, TxHsActive, TxByteReady, TxPktDone, eS, eA, eR, eD);
            end
            if (k == 8)  TxValid = 1'b0;
            if (k == 17) TxValid = 1'b1;
            if (k == 30) TxValid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_burst();
        TxDataIn = 8'hA5;
        TxValid  = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            if (k == 8) TxValid = 1'b0;
        end
        checks++;
        if ({TxHsActive, TxByteReady} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_pre: act/rdy=%b%b expected 11", TxHsActive, TxByteReady);
        end
        #2;
        TxRst = 1'b1;
        #1;
        checks++;
        if ({TxSerialOut, TxHsActive, TxByteReady, TxPktDone} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async: ser/act/rdy/done=%b%b%b%b expected 0000",
                     TxSerialOut, TxHsActive, TxByteReady, TxPktDone);
        end
        #1;
        TxRst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({TxSerialOut, TxHsActive, TxPktDone} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_idle cycle %0d: ser/act/done=%b%b%b expected 000",
                         k, TxSerialOut, TxHsActive, TxPktDone);
            end
        end
        TxValid = 1'b1;
        tick();
        checks++;
        if (TxHsActive !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart_k0: act=%b expected 0", TxHsActive);
        end
        TxValid = 1'b0;
        tick();
        checks++;
        if ({TxSerialOut, TxHsActive} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_restart_k1: ser/act=%b%b expected 01", TxSerialOut, TxHsActive);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        drain(4);
        test_back_to_back();
        drain(4);
        test_empty_packet();
        drain(4);
        test_data_hold();
        drain(4);
        test_rearm();
        drain(30);
        test_reset_mid_burst();
        drain(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tx_hs_serializer
`default_nettype wire

// File: doc/tx_hs_serializer.md
Name: tx_hs_serializer

Overview:
- Stage directly downstream of the transmitter state machine. Consumes its byte stream (TxValid plus an 8-bit byte) and produces one HS serial lane bit per TxDDRClk cycle.
- Wraps the payload as a burst: leader SYNC_WORD, payload bits LSB-first, trail bits, then an exit gap. The downstream analog/DDR pad stage takes TxSerialOut and TxHsActive directly.

Parameters:
- SYNC_WORD, 8'hB8, leader sequence sent LSB-first before the first payload bit.
- TRAIL_BITS, 8, number of trail bits after the last payload bit (legal range 1..255).
- EXIT_CYCLES, 4, minimum idle cycles after trail before a new burst may start (legal range 1..255).

Ports:
- TxDDRClk  input  1  bit clock; all logic on rising edge.
- TxRst  input  1  asynchronous, active-high reset.
- TxValid  input  1  upstream byte valid, level; high for the whole packet.
- TxDataIn  input  8  upstream byte; sampled only when TxByteReady=1.
- TxByteReady  output  1  high in the cycle a byte is consumed. Moore output: decoded from state and bit counter only, no combinational path from TxValid.
- TxSerialOut  output  1  serial lane bit.
- TxHsActive  output  1  high from first SYNC bit through last trail bit.
- TxPktDone  output  1  one-cycle pulse in the last trail cycle.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, counters and shift register 0. Takes effect immediately mid-burst; no trail is sent. After release, the block sits in IDLE; EXIT is not required.
- States: IDLE, SYNC, DATA, TRAIL, EXIT. BitCnt is 3 bits. Trail and exit counters are 8 bits.
- IDLE: TxSerialOut=0, TxHsActive=0.
  - TxValid=1 sampled at a rising edge -> SYNC next cycle, BitCnt=0.
- SYNC: TxHsActive=1, TxSerialOut=SYNC_WORD[BitCnt], BitCnt increments.
  - Cycle with BitCnt=7: TxByteReady=1.
    - TxValid=1 -> load TxDataIn into the shift register, go to DATA, BitCnt=0.
    - TxValid=0 (empty packet) -> go to TRAIL, TrailBit=~SYNC_WORD[7].
- DATA: TxSerialOut=Shift[BitCnt] (LSB first), BitCnt increments.
  - Cycle with BitCnt=7: TxByteReady=1.
    - TxValid=1 -> load next byte, stay in DATA, BitCnt wraps to 0 with no bubble.
    - TxValid=0 -> go to TRAIL, TrailBit=~Shift[7].
- TxByteReady=1 with TxValid=0 consumes nothing; upstream must not treat it as an accept.
- TRAIL: TxSerialOut=TrailBit for exactly TRAIL_BITS cycles, TxHsActive=1.
  - TxPktDone=1 in the final trail cycle.
  - Then go to EXIT.
- EXIT: TxSerialOut=0, TxHsActive=0 for EXIT_CYCLES cycles. TxValid is ignored.
  - Then go to IDLE. A TxValid still high re-arms a new burst on the next edge.
- Latency: first payload bit appears 9 cycles after the edge that samples TxValid=1 in IDLE (1 cycle to enter SYNC + 8 SYNC cycles).
- Throughput: one byte per 8 cycles, back-to-back.
- TxValid dropping mid-byte has no effect until the BitCnt=7 decision point; the current byte always completes.
- TxDataIn changing outside TxByteReady cycles has no effect.

Decomposition:
- Shared package (mipi_tx_pkg): state encodings (3-bit localparams for IDLE, SYNC, DATA, TRAIL, EXIT) and the default values of SYNC_WORD, TRAIL_BITS and EXIT_CYCLES, shared with the RX sync detector.
- One natural sub-module, tx_shift8: 8-bit load/shift register with BitCnt and a bit-select output. The FSM and trail/exit counters stay in the top module.

Test Plan:
- Reset during DATA: assert TxRst mid-byte -> TxSerialOut, TxHsActive, TxByteReady and TxPktDone go 0 immediately; IDLE after release; TxHsActive=0 until TxValid=1 is sampled again.
- Single byte: TxValid high for one byte with TxDataIn=8'hA5 -> 9 cycles after the sampling edge, the line carries 0,0,0,1,1,1,0,1 (SYNC) then 1,0,1,0,0,1,0,1. Then eight trail bits of 0 (since ~bit7 of A5 = 0), TxPktDone on the 8th trail bit, then 4 cycles with TxHsActive=0.
- Back-to-back: bytes 8'h01, 8'hFF, 8'h80 -> TxByteReady pulses exactly every 8 cycles with no gap. Trail bit is 0 (since ~bit7 of 80 = 0). Total TxHsActive high = 8+24+8 = 40 cycles.
- Empty packet: TxValid drops before SYNC BitCnt=7 -> SYNC then 8 trail bits of 0; TxDataIn never consumed; TxPktDone pulses once.
- Upstream data hold: TxDataIn toggles randomly except in TxByteReady cycles -> serial output matches only the bytes presented at ready.
- Re-arm: TxValid kept high through TRAIL and EXIT -> new SYNC starts exactly 4+1 cycles after the last trail bit.
